ad9518_spi_writer: RTL
======================

# ad9518_spi_writer

Sequencer and 3-wire SPI master that programs the AD9518 clock generator from the register look-up table. It drives `lut_index`, reads back the combinational `{addr, data}` word, and serialises each entry as a 24-bit single-byte write. It runs until the table terminator, then asserts `done`. It sits between the board-level start/reset logic and the AD9518 SPI pins, directly downstream of the LUT.

## Interface
Parameters:
- CLK_DIV, 4: `clk` cycles per SCLK half-period (≥2).
- GAP_CYCLES, 8: minimum CS_n-high cycles between frames.
- RESET_WAIT, 1000: extra idle cycles after any write to address 0x0000.
- VCOCAL_WAIT, 50000: extra idle cycles after a write to 0x0018 with data bit0 = 1.
- LOCK_TRIES, 16: lock-poll attempts (only with `AD9518_LOCK_WAIT_EN`).

Ports:
- clk in 1: system clock.
- rst_n in 1: reset. One clock; reset is asynchronous and active-low.
- start in 1: one-cycle pulse that begins a programming run. Ignored while `busy`.
- lut_index out 10: LUT address.
- lut_data in 25: LUT word, `{pad, addr[15:0], data[7:0]}`. Bit 24 is ignored.
- spi_cs_n out 1: chip select, active low.
- spi_sclk out 1: SPI clock. Idles low (mode 0).
- spi_sdio_o out 1: serial data out, MSB first.
- spi_sdio_oe out 1: SDIO output enable.
- spi_sdio_i in 1: SDIO input. Used only with the macro.
- busy out 1: high from the cycle after `start` until completion.
- done out 1: level; set on completion, cleared by the next accepted `start`.
- error out 1: lock-poll timeout. Cleared by `start`.

## Operation
- Reset values: `lut_index` = 0, `spi_cs_n` = 1, `spi_sclk` = 0, `spi_sdio_o` = 0, `spi_sdio_oe` = 0, `busy` = 0, `done` = 0, `error` = 0, FSM in IDLE.
- States: IDLE → FETCH → SHIFT → GAP → (WAIT) → FETCH … → FINISH → IDLE.
- On accepted `start`: `lut_index` is set to 0 and the FSM enters FETCH.
- FETCH (one cycle): latch `lut_data`.
  - If `lut_data[23:0]` = 24'hFFFFFF, go to FINISH.
  - Otherwise load the shift register with `{1'b0, 2'b00, addr[12:0], data[7:0]}`. This is a write of 1 byte; `addr[15:13]` is discarded.
- SHIFT: 24 bits, `spi_sdio_oe` = 1. After the last bit, go to GAP.
- GAP: `spi_cs_n` = 1 for GAP_CYCLES cycles, then `lut_index` increments.
- WAIT: entered after GAP, instead of going straight to FETCH, when either condition holds:
  - the frame address was 0x0000 → wait RESET_WAIT cycles;
  - the frame address was 0x0018 with data bit0 = 1 → wait VCOCAL_WAIT cycles.
- Index wrap: if `lut_index` = 1023 completes, FINISH without wrapping.
- FINISH: `busy` = 0, `done` = 1, all SPI outputs at idle values.
- Reset mid-frame: `spi_cs_n` goes to 1 and `spi_sclk` goes to 0 immediately (asynchronously). No partial frame is resumed.

## Timing
- Frame start: `spi_cs_n` falls in cycle T, the cycle after FETCH. Bit 23 is valid on `spi_sdio_o` from cycle T.
- Bit timing:
  - SCLK rises at T + (2k+1)·CLK_DIV for bit k = 0..23.
  - SCLK falls at T + (2k+2)·CLK_DIV.
  - The next bit changes on each falling edge.
- `spi_cs_n` rises at T + 49·CLK_DIV, i.e. one half-period of hold after the last fall. `spi_sdio_oe` drops in the same cycle.
- LUT latency: `lut_index` is stable for at least one cycle before FETCH samples `lut_data`, because the LUT is combinational.
- Run length without waits: 1 + N·(1 + 49·CLK_DIV + GAP_CYCLES + 1) cycles for N valid entries, plus the wait time.

## Configuration
Macro: `AD9518_LOCK_WAIT_EN`.

Defined:
- After the terminator, issue a read of register 0x01F.
  - Instruction `{1'b1, 2'b00, 13'h01F}`: 16 bits driven.
  - Then `spi_sdio_oe` = 0 and 8 bits are sampled on SCLK rising edges.
- If bit0 (digital lock detect) = 1: FINISH with `error` = 0.
- Otherwise wait RESET_WAIT cycles and retry.
- After LOCK_TRIES failures: FINISH with `done` = 1 and `error` = 1.

Undefined:
- No read frames are issued.
- `spi_sdio_i` is unused.
- `error` is tied to 0.

## Test plan
- Reset → all outputs at reset values. Assert `rst_n` during SHIFT → `spi_cs_n` = 1 within the same cycle, with no clock edge required.
- Frame check, CLK_DIV = 4: `start` with entry 0 = {0x0000, 0x3C} → SDIO shows 0x00003C MSB-first, sampled on 24 rising edges. CS_n low for 196 cycles.
- Full table of 37 entries plus terminator at index 37 → exactly 37 frames.
  - Check: a RESET_WAIT gap after each of frames 0 and 1.
  - Check: a VCOCAL_WAIT gap after frame 35 ({0x0018, 0x07}).
  - Check: no VCOCAL_WAIT gap after frame 11 ({0x0018, 0x06}).
  - Check: `done` = 1 and `busy` = 0.
- `start` pulses during `busy` → ignored, frame count unchanged. `start` after `done` → `done` clears and the run repeats from index 0.
- Address bit check: LUT word {0xE232, 0x01} → transmitted instruction is 0x0232, so bits 15:13 are forced to 000.
- With `AD9518_LOCK_WAIT_EN`:
  - Model returns 0x00 twice, then 0x01 → 3 read frames, then `done` = 1, `error` = 0.
  - Model always returns 0x00 → LOCK_TRIES reads, then `error` = 1.

Source files
------------

// File: rtl/ad9518_spi_writer_if.sv
// ---------------------------------------------------------------------------
// ad9518_spi_writer_if
// Bundles the control handshake, the LUT read port and the 3-wire SPI pins of
// the AD9518 programming sequencer.
//   start       : one-cycle pulse that begins a programming run
//   lut_index   : LUT address driven by the sequencer
//   lut_data    : combinational LUT word {pad, addr[15:0], data[7:0]}
//   spi_cs_n    : chip select, active low
//   spi_sclk    : SPI clock, idles low
//   spi_sdio_o  : serial data out, MSB first
//   spi_sdio_oe : SDIO output enable
//   spi_sdio_i  : SDIO input (lock-poll reads only)
//   busy/done   : run status
//   error       : lock-poll timeout
// Modports: master = the sequencer, slave = its environment (LUT, pins, host).
// ---------------------------------------------------------------------------
interface ad9518_spi_writer_if;
   logic        start;
   logic [9:0]  lut_index;
   logic [24:0] lut_data;
   logic        spi_cs_n;
   logic        spi_sclk;
   logic        spi_sdio_o;
   logic        spi_sdio_oe;
   logic        spi_sdio_i;
   logic        busy;
   logic        done;
   logic        error;

   modport master (
      input  start, lut_data, spi_sdio_i,
      output lut_index, spi_cs_n, spi_sclk, spi_sdio_o, spi_sdio_oe,
             busy, done, error
   );

   modport slave (
      output start, lut_data, spi_sdio_i,
      input  lut_index, spi_cs_n, spi_sclk, spi_sdio_o, spi_sdio_oe,
             busy, done, error
   );
endinterface

// File: rtl/ad9518_spi_writer.sv
// ---------------------------------------------------------------------------
// ad9518_spi_writer
// Walks the AD9518 register LUT from index 0 and sends every entry as a
// 24-bit single-byte SPI write (mode 0, MSB first) until the 24'hFFFFFF
// terminator, inserting settle time after soft reset (addr 0x000) and after a
// VCO calibration request (addr 0x018, data bit0 set).
// Ports:
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   bus   : ad9518_spi_writer_if.master (handshake, LUT port, SPI pins)
// Optional feature: define AD9518_LOCK_WAIT_EN to poll register 0x01F for
// digital lock after the table, retrying up to LOCK_TRIES times and flagging
// error on timeout. Without it no reads happen and error stays low.
// ---------------------------------------------------------------------------
module ad9518_spi_writer #(
   parameter int CLK_DIV     = 4,
   parameter int GAP_CYCLES  = 8,
   parameter int RESET_WAIT  = 1000,
   parameter int VCOCAL_WAIT = 50000,
   parameter int LOCK_TRIES  = 16
) (
   input logic                 clk,
   input logic                 rst_n,
   ad9518_spi_writer_if.master bus
);

   localparam int DIV_W    = $clog2(CLK_DIV + 2);
   localparam int GAP_W    = $clog2(GAP_CYCLES + 2);
   localparam int WAIT_MAX = (RESET_WAIT > VCOCAL_WAIT) ? RESET_WAIT : VCOCAL_WAIT;
   localparam int WAIT_W   = $clog2(WAIT_MAX + 2);

   typedef enum logic [2:0] {
      ST_IDLE, ST_FETCH, ST_SHIFT, ST_GAP, ST_WAIT, ST_LOCK, ST_FINISH
   } state_t;

   state_t              state_q;
   logic [9:0]          lutIndex_q;
   logic [23:0]         shift_q;
   logic [DIV_W-1:0]    divCnt_q;
   logic [5:0]          halfCnt_q;
   logic [GAP_W-1:0]    gapCnt_q;
   logic [WAIT_W-1:0]   waitCnt_q;
   logic                csN_q;
   logic                sclk_q;
   logic                sdo_q;
   logic                sdoOe_q;
   logic                busy_q;
   logic                done_q;
   logic                waitReset_q;
   logic                waitVco_q;
`ifdef AD9518_LOCK_WAIT_EN
   localparam int TRY_W = $clog2(LOCK_TRIES + 2);
   logic                isRead_q;
   logic                rxBit_q;
   logic [TRY_W-1:0]    lockTries_q;
   logic                error_q;
`endif

   // Pad bit of the LUT word is never used; in the default build neither is SDIO input.
   logic unusedBits;
   assign unusedBits = ^{bus.lut_data[24], bus.spi_sdio_i};

   // Sequencer FSM. Each frame holds CS_n low for 49 SCLK half-periods: 48
   // half-periods of data plus one half-period of hold after the last fall.
   // halfCnt_q counts completed half-periods; entering an odd one raises SCLK,
   // entering an even one lowers it and presents the next bit.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         lutIndex_q  <= '0;
         shift_q     <= '0;
         divCnt_q    <= '0;
         halfCnt_q   <= '0;
         gapCnt_q    <= '0;
         waitCnt_q   <= '0;
         csN_q       <= 1'b1;
         sclk_q      <= 1'b0;
         sdo_q       <= 1'b0;
         sdoOe_q     <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         waitReset_q <= 1'b0;
         waitVco_q   <= 1'b0;
`ifdef AD9518_LOCK_WAIT_EN
         isRead_q    <= 1'b0;
         rxBit_q     <= 1'b0;
         lockTries_q <= '0;
         error_q     <= 1'b0;
`endif
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (bus.start) begin
                  lutIndex_q <= '0;
                  busy_q     <= 1'b1;
                  done_q     <= 1'b0;
                  state_q    <= ST_FETCH;
`ifdef AD9518_LOCK_WAIT_EN
                  isRead_q    <= 1'b0;
                  lockTries_q <= '0;
                  error_q     <= 1'b0;
`endif
               end
            end

            ST_FETCH: begin
               if (bus.lut_data[23:0] == 24'hFFFFFF) begin
`ifdef AD9518_LOCK_WAIT_EN
                  state_q <= ST_LOCK;
`else
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  state_q <= ST_FINISH;
`endif
               end else begin
                  // Write of one byte; the upper three address bits are dropped.
                  shift_q     <= {3'b000, bus.lut_data[20:0]};
                  waitReset_q <= (bus.lut_data[20:8] == 13'h0000);
                  waitVco_q   <= (bus.lut_data[20:8] == 13'h0018) && bus.lut_data[0];
                  csN_q       <= 1'b0;
                  sclk_q      <= 1'b0;
                  sdo_q       <= 1'b0;
                  sdoOe_q     <= 1'b1;
                  divCnt_q    <= '0;
                  halfCnt_q   <= '0;
                  state_q     <= ST_SHIFT;
               end
            end

`ifdef AD9518_LOCK_WAIT_EN
            ST_LOCK: begin
               // Read instruction for register 0x01F followed by 8 input bits.
               isRead_q  <= 1'b1;
               shift_q   <= {1'b1, 2'b00, 13'h001F, 8'h00};
               csN_q     <= 1'b0;
               sclk_q    <= 1'b0;
               sdo_q     <= 1'b1;
               sdoOe_q   <= 1'b1;
               divCnt_q  <= '0;
               halfCnt_q <= '0;
               state_q   <= ST_SHIFT;
            end
`endif

            ST_SHIFT: begin
               if (divCnt_q != DIV_W'(CLK_DIV - 1)) begin
                  divCnt_q <= divCnt_q + DIV_W'(1);
               end else begin
                  divCnt_q <= '0;
                  if (halfCnt_q == 6'd48) begin
                     csN_q    <= 1'b1;
                     sclk_q   <= 1'b0;
                     sdo_q    <= 1'b0;
                     sdoOe_q  <= 1'b0;
                     gapCnt_q <= '0;
                     state_q  <= ST_GAP;
                  end else begin
                     halfCnt_q <= halfCnt_q + 6'd1;
                     sclk_q    <= ~halfCnt_q[0];
                     if (halfCnt_q[0]) begin
                        shift_q <= {shift_q[22:0], 1'b0};
                        sdo_q   <= shift_q[22];
                     end
`ifdef AD9518_LOCK_WAIT_EN
                     // After the 16th bit the device drives SDIO; only the last
                     // sampled bit (lock detect, bit0) needs to be kept.
                     if (isRead_q && halfCnt_q == 6'd31)
                        sdoOe_q <= 1'b0;
                     if (isRead_q && !halfCnt_q[0] && halfCnt_q >= 6'd32)
                        rxBit_q <= bus.spi_sdio_i;
`endif
                  end
               end
            end

            ST_GAP: begin
               if (gapCnt_q != GAP_W'(GAP_CYCLES)) begin
                  gapCnt_q <= gapCnt_q + GAP_W'(1);
`ifdef AD9518_LOCK_WAIT_EN
               end else if (isRead_q) begin
                  if (rxBit_q) begin
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                     state_q <= ST_FINISH;
                  end else if (lockTries_q == TRY_W'(LOCK_TRIES - 1)) begin
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                     error_q <= 1'b1;
                     state_q <= ST_FINISH;
                  end else begin
                     lockTries_q <= lockTries_q + TRY_W'(1);
                     waitCnt_q   <= WAIT_W'(RESET_WAIT - 1);
                     state_q     <= ST_WAIT;
                  end
`endif
               end else if (lutIndex_q == 10'd1023) begin
`ifdef AD9518_LOCK_WAIT_EN
                  state_q <= ST_LOCK;
`else
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  state_q <= ST_FINISH;
`endif
               end else begin
                  lutIndex_q <= lutIndex_q + 10'd1;
                  if (waitReset_q) begin
                     waitCnt_q <= WAIT_W'(RESET_WAIT - 1);
                     state_q   <= ST_WAIT;
                  end else if (waitVco_q) begin
                     waitCnt_q <= WAIT_W'(VCOCAL_WAIT - 1);
                     state_q   <= ST_WAIT;
                  end else begin
                     state_q <= ST_FETCH;
                  end
               end
            end

            ST_WAIT: begin
               if (waitCnt_q != '0) begin
                  waitCnt_q <= waitCnt_q - WAIT_W'(1);
               end else begin
`ifdef AD9518_LOCK_WAIT_EN
                  state_q <= isRead_q ? ST_LOCK : ST_FETCH;
`else
                  state_q <= ST_FETCH;
`endif
               end
            end

            ST_FINISH: state_q <= ST_IDLE;

            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign bus.lut_index   = lutIndex_q;
   assign bus.spi_cs_n    = csN_q;
   assign bus.spi_sclk    = sclk_q;
   assign bus.spi_sdio_o  = sdo_q;
   assign bus.spi_sdio_oe = sdoOe_q;
   assign bus.busy        = busy_q;
   assign bus.done        = done_q;
`ifdef AD9518_LOCK_WAIT_EN
   assign bus.error       = error_q;
`else
   assign bus.error       = 1'b0;
`endif

endmodule
